// File: rtl/bcd_conv_arbiter_if.sv
// Requester and converter signal bundle for the shared binary-to-BCD converter arbiter.
// The slave side is the arbiter; the master side is the requesters plus the external converter.
interface bcd_conv_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    localparam int unsigned BW = 6;

    logic [NREQ-1:0]    req;
    logic [BW*NREQ-1:0] bin_flat;
    logic [NREQ-1:0]    ack;
    logic [BW-1:0]      rsp_bcd;
    logic               rsp_err;
    logic [IDW-1:0]     rsp_id;
    logic               busy;
    logic               conv_g_n;
    logic [BW-1:0]      conv_bin;
    logic [BW-1:0]      conv_bcd;

    modport master (
        output req, bin_flat, conv_bcd,
        input  ack, rsp_bcd, rsp_err, rsp_id, busy, conv_g_n, conv_bin
    );

    modport slave (
        input  req, bin_flat, conv_bcd,
        output ack, rsp_bcd, rsp_err, rsp_id, busy, conv_g_n, conv_bin
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one external 6-bit binary-to-BCD converter among NREQ requesters.
// Holds the converter inputs for SETTLE cycles, captures the result and acks the grantee for one cycle.
module bcd_conv_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = 2,
    parameter int unsigned SETTLE = 3
) (
    input  logic                clk,
    input  logic                reset,
    bcd_conv_arbiter_if.slave   bus
);
    localparam int unsigned BW = 6;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [BW-1:0] ERR_CODE = BW'(6'h3F);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [BW-1:0]   rsp_bcd_q, rsp_bcd_d;
    logic            rsp_err_q, rsp_err_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            busy_q, busy_d;
    logic            g_n_q, g_n_d;
    logic [BW-1:0]   bin_q, bin_d;

    logic            found;
    int unsigned     pick;
    int unsigned     scan_idx;

    // First pending request at or after rr_q, wrapping modulo NREQ
    always_comb begin
        found    = 1'b0;
        pick     = 0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = (32'(rr_q) + k) % NREQ;
            if (!found && (((bus.req >> scan_idx) & NREQ'(1)) != '0)) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        rsp_bcd_d = rsp_bcd_q;
        rsp_err_d = rsp_err_q;
        rsp_id_d  = rsp_id_q;
        busy_d    = busy_q;
        g_n_d     = g_n_q;
        bin_d     = bin_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = IDW'(pick);
                    bin_d   = BW'(bus.bin_flat >> (BW * pick));
                    g_n_d   = 1'b0;
                    cnt_d   = CW'(SETTLE - 1);
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Converter inputs have been stable for SETTLE cycles once cnt reaches zero
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rsp_bcd_d = bus.conv_bcd;
                    rsp_err_d = (bus.conv_bcd == ERR_CODE);
                    rsp_id_d  = grant_q;
                    ack_d     = NREQ'(1) << grant_q;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                g_n_d   = 1'b1;
                busy_d  = 1'b0;
                rr_d    = IDW'((32'(grant_q) + 32'(1)) % NREQ);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            rsp_bcd_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_id_q  <= '0;
            busy_q    <= 1'b0;
            g_n_q     <= 1'b1;
            bin_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            rsp_bcd_q <= rsp_bcd_d;
            rsp_err_q <= rsp_err_d;
            rsp_id_q  <= rsp_id_d;
            busy_q    <= busy_d;
            g_n_q     <= g_n_d;
            bin_q     <= bin_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rsp_bcd  = rsp_bcd_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.rsp_id   = rsp_id_q;
    assign bus.busy     = busy_q;
    assign bus.conv_g_n = g_n_q;
    assign bus.conv_bin = bin_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed scenarios plus random requests against a
// transaction-level model of the round-robin converter sharing.
module tb_bcd_conv_arbiter;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned IDW    = 2;
    localparam int unsigned SETTLE = 3;
    localparam int unsigned VW     = 6 * NREQ;
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RESP = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    bcd_conv_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    bcd_conv_arbiter #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [NREQ-1:0] req_v = '0;
    logic [VW-1:0]   vals  = '0;
    assign bus.req      = req_v;
    assign bus.bin_flat = vals;

    // External converter: 0..39 -> tens/units BCD, otherwise all ones; 40 time units of delay
    function automatic logic [5:0] conv_model(input logic [5:0] b);
        int v;
        v = int'(b);
        if (v > 39) return 6'h3F;
        return 6'((v / 10) * 16 + (v % 10));
    endfunction
    assign #40 bus.conv_bcd = bus.conv_g_n ? 6'h00 : conv_model(bus.conv_bin);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Transaction model state
    int          m_phase = M_IDLE;
    int          m_rr    = 0;
    int          m_grant = 0;
    int          m_left  = 0;
    logic [5:0]  e_bin   = '0;
    logic [5:0]  e_bcd   = '0;
    logic        e_err   = 1'b0;
    int          e_id    = 0;

    int cyc     = 0;
    int ack_cyc = -1;
    bit gap_on  = 1'b0;
    bit order_on = 1'b0;
    int ord [8];
    int ord_n = 0;
    int ord_k = 0;

    function automatic logic req_at(input int i);
        return ((req_v >> i) & NREQ'(1)) != '0;
    endfunction

    task automatic set_req(input int i, input logic [5:0] v);
        vals  = (vals & ~(VW'(6'h3F) << (6 * i))) | (VW'(v) << (6 * i));
        req_v = req_v | (NREQ'(1) << i);
    endtask

    task automatic drop_req(input int i);
        req_v = req_v & ~(NREQ'(1) << i);
    endtask

    task automatic model_reset();
        m_phase = M_IDLE;
        m_rr    = 0;
        e_bin   = '0;
        e_bcd   = '0;
        e_err   = 1'b0;
        e_id    = 0;
    endtask

    // Advance the model over one edge, then compare every output
    task automatic cycle();
        case (m_phase)
            M_IDLE: begin
                if (req_v != '0) begin
                    for (int k = 0; k < int'(NREQ); k++) begin
                        int idx;
                        idx = (m_rr + k) % int'(NREQ);
                        if (req_at(idx)) begin
                            m_grant = idx;
                            break;
                        end
                    end
                    e_bin   = 6'(vals >> (6 * m_grant));
                    m_left  = SETTLE;
                    m_phase = M_WAIT;
                end
            end
            M_WAIT: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = M_RESP;
                    e_bcd   = conv_model(e_bin);
                    e_err   = (e_bin > 6'd39);
                    e_id    = m_grant;
                end
            end
            default: begin
                m_phase = M_IDLE;
                m_rr    = (m_grant + 1) % int'(NREQ);
            end
        endcase

        @(posedge clk);
        #1;
        cyc++;
        check("ack",      bus.ack,      (m_phase == M_RESP) ? (1 << m_grant) : 0);
        check("busy",     bus.busy,     (m_phase != M_IDLE) ? 1 : 0);
        check("conv_g_n", bus.conv_g_n, (m_phase == M_IDLE) ? 1 : 0);
        check("conv_bin", bus.conv_bin, e_bin);
        check("rsp_bcd",  bus.rsp_bcd,  e_bcd);
        check("rsp_err",  bus.rsp_err,  e_err);
        check("rsp_id",   bus.rsp_id,   e_id);
        if (bus.ack != '0) begin
            if (gap_on && ack_cyc >= 0) check("ack_gap", cyc - ack_cyc, SETTLE + 2);
            ack_cyc = cyc;
            if (order_on && ord_k < ord_n) begin
                check("ack_order", bus.rsp_id, ord[ord_k]);
                ord_k++;
            end
        end
        @(negedge clk);
    endtask

    // Requesters: drop on ack, re-raise held ones, raise others with probability pct
    task automatic run(input int n, input logic [NREQ-1:0] hold, input int pct);
        repeat (n) begin
            if (m_phase == M_RESP) begin
                drop_req(m_grant);
            end else begin
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (!req_at(i)) begin
                        if (((hold >> i) & NREQ'(1)) != '0)
                            req_v = req_v | (NREQ'(1) << i);
                        else if ($urandom_range(99) < 32'(pct))
                            set_req(i, 6'($urandom_range(63)));
                    end
                end
            end
            cycle();
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((req_v != '0 || m_phase != M_IDLE) && k < 200) begin
            run(1, '0, 0);
            k++;
        end
        if (k >= 200) check("drain_timeout", 1, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},  bus.ack,      0);
        check({tag, "_busy"}, bus.busy,     0);
        check({tag, "_gn"},   bus.conv_g_n, 1);
        check({tag, "_bin"},  bus.conv_bin, 0);
        check({tag, "_bcd"},  bus.rsp_bcd,  0);
        check({tag, "_err"},  bus.rsp_err,  0);
        check({tag, "_id"},   bus.rsp_id,   0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_v = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        logic [5:0] bvals [4];
        logic [5:0] bexp  [4];
        bvals = '{6'd0, 6'd39, 6'd40, 6'd63};
        bexp  = '{6'h00, 6'h39, 6'h3F, 6'h3F};

        apply_reset();

        // Single request, value 37
        set_req(1, 6'd37);
        drain();
        check("t1_bcd", bus.rsp_bcd, 6'h37);
        check("t1_err", bus.rsp_err, 0);
        check("t1_id",  bus.rsp_id,  1);

        // Range boundaries on one requester
        for (int i = 0; i < 4; i++) begin
            set_req(0, bvals[i]);
            drain();
            check("bnd_bcd", bus.rsp_bcd, bexp[i]);
            check("bnd_err", bus.rsp_err, (i >= 2) ? 1 : 0);
        end

        // All requesters from reset: served 0,1,2,3 at SETTLE+2 spacing
        apply_reset();
        for (int i = 0; i < int'(NREQ); i++) set_req(i, 6'($urandom_range(63)));
        ord = '{0, 1, 2, 3, 0, 0, 0, 0};
        ord_n = 4; ord_k = 0; ack_cyc = -1;
        gap_on = 1'b1; order_on = 1'b1;
        drain();
        gap_on = 1'b0; order_on = 1'b0;
        check("all4_cnt", ord_k, 4);

        // Two persistent requesters alternate
        ord = '{0, 2, 0, 2, 0, 2, 0, 2};
        ord_n = 8; ord_k = 0;
        set_req(0, 6'd12);
        set_req(2, 6'd33);
        order_on = 1'b1;
        run(45, 4'b0101, 0);
        order_on = 1'b0;
        check("alt_cnt", ord_k, 8);
        drain();

        // Reset one cycle into WAIT
        set_req(1, 6'd10);
        cycle();
        check("pre_rst_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_ack",  bus.ack,      0);
        check("rst_mid_busy", bus.busy,     0);
        check("rst_mid_gn",   bus.conv_g_n, 1);
        model_reset();
        req_v = '0;
        cycle();
        reset = 1'b0;
        set_req(3, 6'd21);
        c0 = cyc;
        drain();
        check("rst_lat", ack_cyc - c0, SETTLE + 1);
        check("rst_id",  bus.rsp_id,  3);
        check("rst_bcd", bus.rsp_bcd, 6'h21);

        // Input changes after the grant are ignored
        set_req(0, 6'd25);
        cycle();
        set_req(0, 6'd50);
        drain();
        check("chg_bcd", bus.rsp_bcd, 6'h25);
        check("chg_err", bus.rsp_err, 0);

        // Random traffic
        run(600, '0, 30);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
Shares one external 6-bit binary-to-BCD converter (active-low enable g_n, 6-bit bin_in, 6-bit bcd_out) among NREQ requesters in the tx_rx system.
Grants one requester at a time using round-robin order.
Drives the converter's inputs, waits a programmable settle time that covers the converter's 40 ns combinational delay, then captures the result.
Returns the result to the granted requester with a one-cycle ack, plus an out-of-range flag.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ
SETTLE, 3, clock cycles the converter inputs are held stable before capture (>= 1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester conversion request; held high until its ack
bin_flat  input  6*NREQ  requester i's value in bin_flat[6*i+5:6*i]; stable while req[i] is high
ack  output  NREQ  one-cycle pulse to the granted requester; result valid in the same cycle
rsp_bcd  output  6  captured BCD result: [5:4] tens, [3:0] units
rsp_err  output  1  captured result was 6'b111111 (input > 39)
rsp_id  output  IDW  index of the requester being acked
busy  output  1  high in WAIT and RESP states
conv_g_n  output  1  converter enable, active low
conv_bin  output  6  converter binary input
conv_bcd  input  6  converter BCD output

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; ack=0; rsp_bcd=0; rsp_err=0; rsp_id=0; busy=0.
  - conv_g_n=1; conv_bin=0; rr_ptr=0; settle counter=0.
- All outputs are registered; conv_bcd is sampled only at capture.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - conv_g_n=1.
  - If any req bit is high at edge E0: grant the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, NREQ-1, 0, …).
  - Latch the grant index.
  - conv_bin <= that requester's 6-bit slice; conv_g_n <= 0; cnt <= SETTLE-1; go to WAIT.
  - No req: stay in IDLE; conv_bin holds its last value.
- WAIT:
  - conv_g_n=0; conv_bin held constant.
  - cnt>0: decrement.
  - cnt==0 at edge E0+SETTLE: capture conv_bcd into rsp_bcd; set rsp_err <= (conv_bcd==6'h3F); rsp_id <= grant; ack[grant] <= 1; go to RESP.
- RESP (exactly one cycle):
  - ack is high in this cycle only; req is ignored.
  - On the next edge: ack <= 0, conv_g_n <= 1, rr_ptr <= grant+1 (wraps to 0 after NREQ-1), go to IDLE.
- rsp_bcd, rsp_err and rsp_id hold their value until the next capture.
- Latency: the ack cycle starts SETTLE edges after the grant edge E0.
- Throughput: one conversion per SETTLE+2 cycles.
- A requester must drop req by the edge that ends its ack cycle. A req still high in IDLE afterwards is treated as a new request.
- req[g] dropping during WAIT does not abort the conversion; ack is still issued.
- Changes to bin_flat after the grant edge are ignored for that conversion.
- Requests arriving during WAIT/RESP wait; none are lost, since req is level-held.
- Unused grant indices (>= NREQ) never occur; rr_ptr wraps modulo NREQ.
- Reset asserted mid-WAIT or mid-RESP: immediate return to reset values with no ack issued. After release, arbitration restarts from rr_ptr=0.

Test Plan:
- SETTLE=3, req[1]=1, bin slice1=37 at E0 → conv_g_n=0 and conv_bin=37 from E0. After edge E0+3: ack=4'b0010, rsp_bcd=6'b11_0111, rsp_err=0, rsp_id=1, for exactly 1 cycle. conv_g_n=1 after E0+4.
- Boundary values, single requester: bin=0 → rsp_bcd=6'b00_0000. bin=39 → 6'b11_1001, rsp_err=0. bin=40 or 63 (converter returns 6'h3F) → rsp_bcd=6'h3F, rsp_err=1.
- All four req high from reset, each dropped on its ack → acks in order 0,1,2,3. Successive ack cycles are SETTLE+2 apart.
- req[0] and req[2] held continuously (re-raised immediately after each ack) → acks alternate 0,2,0,2; no starvation.
- Reset pulsed 1 cycle into WAIT → ack never pulses, conv_g_n=1 and busy=0 immediately. The next req[3] is granted normally with full SETTLE latency.
- Change bin slice during WAIT (25→50) → rsp_bcd=6'b10_0101 (25), rsp_err=0.
